// File: rtl/data_mem_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : data_mem_arbiter
// Brief    : Shares one single-port data memory between the CPU MEM stage and a
//            host/debug port; CPU priority with a bounded host wait.
// Revision : 1.0
// =============================================================================
module data_mem_arbiter #(
    parameter int ADDR_W   = 9,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // CPU MEM stage
    input  logic              i_cpu_req,
    input  logic              i_cpu_we,
    input  logic [ADDR_W-1:0] i_cpu_addr,
    input  logic [DATA_W-1:0] i_cpu_wdata,
    output logic              o_cpu_gnt,
    output logic              o_cpu_stall,
    output logic              o_cpu_rvalid,
    output logic [DATA_W-1:0] o_cpu_rdata,
    // Host / debug port
    input  logic              i_host_req,
    input  logic              i_host_we,
    input  logic [ADDR_W-1:0] i_host_addr,
    input  logic [DATA_W-1:0] i_host_wdata,
    output logic              o_host_gnt,
    output logic              o_host_rvalid,
    output logic [DATA_W-1:0] o_host_rdata,
    // Memory macro
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata
);

    localparam logic [1:0] C_OWN_NONE = 2'd0;
    localparam logic [1:0] C_OWN_CPU  = 2'd1;
    localparam logic [1:0] C_OWN_HOST = 2'd2;

    logic       w_cpu_req;
    logic       w_host_req;
    logic       w_host_wins;
    logic       w_cpu_gnt;
    logic       w_host_gnt;
    logic [1:0] r_rd_owner;
    logic [1:0] w_rd_owner_nxt;

    // Requests are masked while reset is held so every output reads 0.
    assign w_cpu_req  = i_cpu_req & rst_n;
    assign w_host_req = i_host_req & rst_n;

    // -------------------------------------------------------------------------
    // Host starvation bound
    // -------------------------------------------------------------------------
    generate
        if (MAX_WAIT == 0) begin : g_host_always_wins
            assign w_host_wins = 1'b1;
        end else begin : g_starve_bound
            localparam int               CNT_W      = $clog2(MAX_WAIT + 1);
            localparam logic [CNT_W-1:0] C_MAX_WAIT = CNT_W'(MAX_WAIT);

            logic [CNT_W-1:0] r_starve_cnt;
            logic [CNT_W-1:0] w_starve_cnt_nxt;

            assign w_host_wins = (r_starve_cnt >= C_MAX_WAIT);

            always_comb begin
                w_starve_cnt_nxt = '0;
                if (w_host_req && !w_host_gnt) begin
                    if (r_starve_cnt < C_MAX_WAIT) begin
                        w_starve_cnt_nxt = r_starve_cnt + CNT_W'(1);
                    end else begin
                        w_starve_cnt_nxt = r_starve_cnt;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_starve_cnt <= '0;
                end else begin
                    r_starve_cnt <= w_starve_cnt_nxt;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Grant decision (combinational, zero wait when uncontended)
    // -------------------------------------------------------------------------
    always_comb begin
        w_host_gnt = w_host_req & (~w_cpu_req | w_host_wins);
        w_cpu_gnt  = w_cpu_req & ~w_host_gnt;
    end

    assign o_cpu_gnt   = w_cpu_gnt;
    assign o_host_gnt  = w_host_gnt;
    assign o_cpu_stall = w_cpu_req & ~w_cpu_gnt;
    assign o_mem_en    = w_cpu_gnt | w_host_gnt;

    always_comb begin
        o_mem_we    = 1'b0;
        o_mem_addr  = '0;
        o_mem_wdata = '0;
        if (w_cpu_gnt) begin
            o_mem_we    = i_cpu_we;
            o_mem_addr  = i_cpu_addr;
            o_mem_wdata = i_cpu_wdata;
        end else if (w_host_gnt) begin
            o_mem_we    = i_host_we;
            o_mem_addr  = i_host_addr;
            o_mem_wdata = i_host_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Read-owner FSM: remembers who issued last cycle's read
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_owner <= C_OWN_NONE;
        end else begin
            r_rd_owner <= w_rd_owner_nxt;
        end
    end

    always_comb begin
        w_rd_owner_nxt = C_OWN_NONE;
        if (w_cpu_gnt && !i_cpu_we) begin
            w_rd_owner_nxt = C_OWN_CPU;
        end else if (w_host_gnt && !i_host_we) begin
            w_rd_owner_nxt = C_OWN_HOST;
        end
    end

    always_comb begin
        o_cpu_rvalid  = 1'b0;
        o_cpu_rdata   = '0;
        o_host_rvalid = 1'b0;
        o_host_rdata  = '0;
        case (r_rd_owner)
            C_OWN_CPU: begin
                o_cpu_rvalid = 1'b1;
                o_cpu_rdata  = i_mem_rdata;
            end
            C_OWN_HOST: begin
                o_host_rvalid = 1'b1;
                o_host_rdata  = i_mem_rdata;
            end
            default: begin
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// =============================================================================
// Module   : tb_data_mem_arbiter
// Brief    : Randomized + directed bench with a queue scoreboard for read data.
// Revision : 1.0
// =============================================================================
module tb_data_mem_arbiter;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 32;
    localparam int MW     = 4;
    localparam int DEPTH  = 512;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Main DUT (MAX_WAIT = 4)
    logic              cpu_req = 0, cpu_we = 0, host_req = 0, host_we = 0;
    logic [ADDR_W-1:0] cpu_addr = '0, host_addr = '0;
    logic [DATA_W-1:0] cpu_wdata = '0, host_wdata = '0;
    logic              cpu_gnt, cpu_stall, cpu_rvalid, host_gnt, host_rvalid;
    logic [DATA_W-1:0] cpu_rdata, host_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(MW)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
        .o_cpu_gnt(cpu_gnt), .o_cpu_stall(cpu_stall), .o_cpu_rvalid(cpu_rvalid), .o_cpu_rdata(cpu_rdata),
        .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
        .o_host_gnt(host_gnt), .o_host_rvalid(host_rvalid), .o_host_rdata(host_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata)
    );

    // Second DUT with MAX_WAIT = 0
    logic              b_cpu_req = 0, b_host_req = 0;
    logic [ADDR_W-1:0] b_cpu_addr = '0, b_host_addr = '0;
    logic              b_cpu_gnt, b_cpu_stall, b_cpu_rvalid, b_host_gnt, b_host_rvalid;
    logic [DATA_W-1:0] b_cpu_rdata, b_host_rdata;
    logic              b_mem_en, b_mem_we;
    logic [ADDR_W-1:0] b_mem_addr;
    logic [DATA_W-1:0] b_mem_wdata;
    logic [DATA_W-1:0] b_mem_rdata = '0;

    data_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n),
        .i_cpu_req(b_cpu_req), .i_cpu_we(1'b0), .i_cpu_addr(b_cpu_addr), .i_cpu_wdata(32'h0),
        .o_cpu_gnt(b_cpu_gnt), .o_cpu_stall(b_cpu_stall), .o_cpu_rvalid(b_cpu_rvalid), .o_cpu_rdata(b_cpu_rdata),
        .i_host_req(b_host_req), .i_host_we(1'b0), .i_host_addr(b_host_addr), .i_host_wdata(32'h0),
        .o_host_gnt(b_host_gnt), .o_host_rvalid(b_host_rvalid), .o_host_rdata(b_host_rdata),
        .o_mem_en(b_mem_en), .o_mem_we(b_mem_we), .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata),
        .i_mem_rdata(b_mem_rdata)
    );

    // Memory macro stand-ins
    logic [DATA_W-1:0] macro_mem [DEPTH];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) macro_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= macro_mem[mem_addr];
        end
    end

    always @(posedge clk) begin
        if (b_mem_en && !b_mem_we) b_mem_rdata <= {23'd0, b_mem_addr} ^ 32'h5A5A_0000;
    end

    // Bookkeeping
    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: memory image, host wait count and read-return queues
    typedef struct {
        int                due;
        logic [DATA_W-1:0] data;
    } exp_t;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    int   model_wait = 0;
    exp_t cpu_q[$];
    exp_t host_q[$];

    always @(negedge clk) begin
        logic e_c, e_h;
        if (!rst_n) begin
            model_wait = 0;
            cpu_q.delete();
            host_q.delete();
            check("rst_ctrl", {cpu_gnt, cpu_stall, cpu_rvalid, host_gnt, host_rvalid, mem_en, mem_we}, 64'd0);
            check("rst_bus", {63'd0, |{mem_addr, mem_wdata, cpu_rdata, host_rdata}}, 64'd0);
        end else begin
            e_h = host_req && (!cpu_req || model_wait >= MW);
            e_c = cpu_req && !e_h;
            check("cpu_gnt", cpu_gnt, e_c);
            check("host_gnt", host_gnt, e_h);
            check("cpu_stall", cpu_stall, cpu_req && !e_c);
            check("mem_en", mem_en, e_c || e_h);
            if (e_c) begin
                check("mem_bus_cpu", {mem_we, mem_addr, mem_wdata}, {cpu_we, cpu_addr, cpu_wdata});
                if (cpu_we) ref_mem[cpu_addr] = cpu_wdata;
                else        cpu_q.push_back('{due: cyc + 1, data: ref_mem[cpu_addr]});
            end else if (e_h) begin
                check("mem_bus_host", {mem_we, mem_addr, mem_wdata}, {host_we, host_addr, host_wdata});
                if (host_we) ref_mem[host_addr] = host_wdata;
                else         host_q.push_back('{due: cyc + 1, data: ref_mem[host_addr]});
            end else begin
                check("mem_bus_idle", {mem_we, mem_addr, mem_wdata}, 64'd0);
            end
            if (host_req && !e_h) model_wait = (model_wait < MW) ? model_wait + 1 : MW;
            else                  model_wait = 0;
        end
    end

    // Monitor: pops expected read data whenever a port presents rvalid
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (cpu_rvalid) begin
                if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
                    e = cpu_q.pop_front();
                    check("cpu_rdata", cpu_rdata, e.data);
                end else begin
                    check("cpu_rvalid_unexpected", cpu_rvalid, 1'b0);
                end
            end else begin
                check("cpu_rdata_idle", cpu_rdata, 64'd0);
                if (cpu_q.size() > 0 && cpu_q[0].due == cyc) begin
                    void'(cpu_q.pop_front());
                    check("cpu_rvalid", cpu_rvalid, 1'b1);
                end
            end
            if (host_rvalid) begin
                if (host_q.size() > 0 && host_q[0].due == cyc) begin
                    e = host_q.pop_front();
                    check("host_rdata", host_rdata, e.data);
                end else begin
                    check("host_rvalid_unexpected", host_rvalid, 1'b0);
                end
            end else begin
                check("host_rdata_idle", host_rdata, 64'd0);
                if (host_q.size() > 0 && host_q[0].due == cyc) begin
                    void'(host_q.pop_front());
                    check("host_rvalid", host_rvalid, 1'b1);
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Stimulus
    initial begin
        int n_host;
        int first_host;
        logic gc, gh;

        // Reset held with both ports requesting
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h000; cpu_wdata = 32'h1111_1111;
        host_req = 1; host_we = 1; host_addr = 9'h001; host_wdata = 32'h2222_2222;
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        next_cycle();
        cpu_req = 0; host_req = 0;
        next_cycle();

        // CPU write then read of the same word
        cpu_req = 1; cpu_we = 1; cpu_addr = 9'h010; cpu_wdata = 32'hDEAD_BEEF;
        next_cycle();
        cpu_we = 0; cpu_wdata = 32'h0;
        next_cycle();
        cpu_req = 0;
        repeat (2) next_cycle();

        // Continuous contention: host should win once every MW+1 cycles
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        host_req = 1; host_we = 0; host_addr = 9'h010;
        n_host = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (host_gnt) n_host++;
            next_cycle();
        end
        check("contention_host_grants", n_host, 3);
        cpu_req = 0; host_req = 0;
        repeat (2) next_cycle();

        // Host preload of the whole memory, then back-to-back dump
        host_req = 1; host_we = 1;
        for (int a = 0; a < DEPTH; a++) begin
            host_addr = a[ADDR_W-1:0];
            host_wdata = $urandom;
            next_cycle();
        end
        host_we = 0; host_wdata = '0;
        n_host = 0;
        for (int a = 0; a < DEPTH; a++) begin
            host_addr = a[ADDR_W-1:0];
            @(negedge clk);
            if (host_gnt) n_host++;
            next_cycle();
        end
        host_req = 0;
        check("dump_grants", n_host, DEPTH);
        repeat (2) next_cycle();

        // Randomized mixed traffic on a small address window
        for (int n = 0; n < 800; n++) begin
            if (!cpu_req && $urandom_range(0, 99) < 60) begin
                cpu_req = 1; cpu_we = ($urandom_range(0, 2) == 0);
                cpu_addr = ADDR_W'($urandom_range(0, 15)); cpu_wdata = $urandom;
            end
            if (!host_req && $urandom_range(0, 99) < 40) begin
                host_req = 1; host_we = ($urandom_range(0, 1) == 0);
                host_addr = ADDR_W'($urandom_range(0, 15)); host_wdata = $urandom;
            end else if (host_req && $urandom_range(0, 19) == 0) begin
                host_req = 0;
            end
            @(negedge clk);
            gc = cpu_gnt; gh = host_gnt;
            next_cycle();
            if (gc) cpu_req = 0;
            if (gh) host_req = 0;
        end
        cpu_req = 0; host_req = 0;
        repeat (3) next_cycle();

        // Reset the cycle after a host read grant: the return must be dropped
        host_req = 1; host_we = 0; host_addr = 9'h005;
        next_cycle();
        host_req = 0;
        rst_n = 0;
        @(negedge clk);
        check("rst_mid_read_host_rvalid", host_rvalid, 1'b0);
        next_cycle();
        rst_n = 1;
        repeat (4) next_cycle();

        // Reset while the host is starving clears the wait count
        cpu_req = 1; cpu_we = 0; cpu_addr = 9'h010;
        host_req = 1; host_we = 0; host_addr = 9'h011;
        repeat (3) next_cycle();
        rst_n = 0;
        next_cycle();
        rst_n = 1;
        first_host = -1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (host_gnt && first_host < 0) first_host = i;
            next_cycle();
        end
        check("post_reset_first_host_grant", first_host, MW);
        cpu_req = 0; host_req = 0;
        repeat (2) next_cycle();

        // MAX_WAIT = 0: host wins every tie, CPU stalls throughout
        b_cpu_req = 1; b_cpu_addr = 9'h007; b_host_req = 1;
        for (int i = 0; i < 8; i++) begin
            b_host_addr = ADDR_W'(i + 1);
            @(negedge clk);
            check("w0_host_gnt", b_host_gnt, 1'b1);
            check("w0_cpu_gnt", b_cpu_gnt, 1'b0);
            check("w0_cpu_stall", b_cpu_stall, 1'b1);
            check("w0_cpu_rvalid", b_cpu_rvalid, 1'b0);
            if (i > 0) begin
                check("w0_host_rvalid", b_host_rvalid, 1'b1);
                check("w0_host_rdata", b_host_rdata, 32'h5A5A_0000 ^ 32'(i));
            end
            next_cycle();
        end
        b_cpu_req = 0; b_host_req = 0;
        repeat (2) next_cycle();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
